// File: rtl/drv_segment_scan.sv
// Multiplexed 7-segment display scanner: time-slices p_count digits on a shared segment bus.
// Latency: outputs registered; a digit lights p_blank clocks into its slot, inputs sampled once per slot.
// Backpressure: none; free-running scan, i_enable low blanks and parks the scanner at digit 0.
//
// Ports:
//   i_clk, i_rst     clock, asynchronous active-low reset
//   i_value, i_dp    per-digit value (index 0 = least significant) and decimal-point request
//   i_enable         scan enable; low forces every output off
//   o_sgmnt, o_dp    shared segment bus (bit 0 = a .. bit 6 = g) and decimal point, active-high
//   o_digit          one-hot digit select, all zero during dead time
//   o_frame          one-clock pulse on the last lit clock of the last digit
//
// Build option: define SEG_LZ_BLANK_EN to compile in leading-zero suppression.

module drv_segment_scan #(
    parameter int p_count   = 4,
    parameter int p_divider = 50_000,
    parameter int p_blank   = 500
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [3:0]         i_value [p_count-1:0],
    input  logic [p_count-1:0] i_dp,
    input  logic               i_enable,
    output logic [6:0]         o_sgmnt,
    output logic               o_dp,
    output logic [p_count-1:0] o_digit,
    output logic               o_frame
);

    localparam int CW = (p_divider > 1) ? $clog2(p_divider) : 1;
    localparam int IW = (p_count > 1) ? $clog2(p_count) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(p_divider - 1);
    localparam logic [CW-1:0] PRE_LAST   = CW'(p_divider - 2);
    localparam logic [CW-1:0] BLANK_LAST = CW'(p_blank - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(p_count - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    // Low after reset or while disabled. The first enabled clock only arms the
    // scanner, so that clock becomes cnt 0 of a complete dead time for digit 0.
    logic          run;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;  // 10..15 shown as a dash
        endcase
        return s;
    endfunction

`ifdef SEG_LZ_BLANK_EN
    // Current digit is a leading zero: not digit 0, and it plus every higher digit is zero.
    logic lz_zero;
    always_comb begin
        lz_zero = (idx != '0);
        for (int j = 0; j < p_count; j++) begin
            if (j >= int'(idx) && i_value[j] != 4'd0) begin
                lz_zero = 1'b0;
            end
        end
    end
`endif

    // Selection for the digit about to be lit; only sampled on the BLANK->SHOW edge.
    logic [6:0]         sel_seg;
    logic               sel_dp;
    logic [p_count-1:0] sel_onehot;

    always_comb begin
        sel_seg         = seg_decode(i_value[idx]);
        sel_dp          = i_dp[idx];
        sel_onehot      = '0;
        sel_onehot[idx] = 1'b1;
`ifdef SEG_LZ_BLANK_EN
        if (lz_zero) begin
            sel_seg = '0;
        end
`endif
    end

    // o_sgmnt/o_dp double as the holding register: they capture the digit once
    // per slot, so input changes mid-slot stay invisible until the next slot.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= BLANK;
            cnt     <= '0;
            idx     <= '0;
            run     <= 1'b0;
            o_sgmnt <= '0;
            o_dp    <= 1'b0;
            o_digit <= '0;
            o_frame <= 1'b0;
        end else if (!i_enable || !run) begin
            state   <= BLANK;
            cnt     <= '0;
            idx     <= '0;
            run     <= i_enable;
            o_sgmnt <= '0;
            o_dp    <= 1'b0;
            o_digit <= '0;
            o_frame <= 1'b0;
        end else if (cnt == DIV_LAST) begin
            state   <= BLANK;
            cnt     <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            o_sgmnt <= '0;
            o_dp    <= 1'b0;
            o_digit <= '0;
            o_frame <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (state == BLANK && cnt == BLANK_LAST) begin
                state   <= SHOW;
                o_sgmnt <= sel_seg;
                o_dp    <= sel_dp;
                o_digit <= sel_onehot;
            end
            // Registered one clock early so the pulse coincides with the final SHOW clock.
            o_frame <= (cnt == PRE_LAST) && (idx == IDX_LAST);
        end
    end

endmodule

// File: doc/drv_segment_scan.md
DRV_SEGMENT_SCAN -- requirements
Module: drv_segment_scan

Interface
REQ-001 Parameter p_count, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter p_divider, default 50_000: clocks per digit slot, blank time included; SHALL be greater than p_blank.
REQ-003 Parameter p_blank, default 500: dead-time clocks at the start of each slot, during which all outputs are off; SHALL be at least 1.
REQ-004 i_clk  input  1  system clock (50 MHz).
REQ-005 i_rst  input  1  asynchronous, active-low reset.
REQ-006 i_value  input  [3:0] x [p_count-1:0] (unpacked)  digit values; index 0 is the least significant digit.
REQ-007 i_dp  input  [p_count-1:0]  decimal-point request per digit.
REQ-008 i_enable  input  1  scan enable; low blanks the display.
REQ-009 o_sgmnt  output  [6:0]  shared segment bus, active-high; bit 0 = a through bit 6 = g.
REQ-010 o_dp  output  1  shared decimal point, active-high.
REQ-011 o_digit  output  [p_count-1:0]  digit select, one-hot active-high, or all zero.
REQ-012 o_frame  output  1  one-clock pulse on completion of a full scan.

Function
REQ-013 FSM states: BLANK and SHOW.
- Slot counter cnt counts 0..p_divider-1.
- Digit index idx counts 0..p_count-1.
REQ-014 BLANK behaviour:
- Held for cnt 0..p_blank-1.
- o_digit = 0, o_sgmnt = 0, o_dp = 0.
REQ-015 BLANK->SHOW transition (cnt = p_blank-1):
- i_value[idx] and i_dp[idx] are latched into a holding register.
- Input changes are not visible until the next slot.
REQ-016 SHOW behaviour:
- Held for cnt p_blank..p_divider-1.
- o_digit = 1 << idx.
- o_sgmnt = decode of the latched value; o_dp = latched dp.
REQ-017 Decode, values 0..9: standard patterns.
- 0 = 7'h3F, 1 = 7'h06, 2 = 7'h5B, 3 = 7'h4F, 4 = 7'h66
- 5 = 7'h6D, 6 = 7'h7D, 7 = 7'h07, 8 = 7'h7F, 9 = 7'h6F
REQ-018 Decode, values 10..15: dash, 7'h40.
REQ-019 End of SHOW (cnt = p_divider-1): cnt -> 0, state -> BLANK, idx increments.
REQ-020 Wrap-around: idx at p_count-1 wraps to 0 and o_frame pulses high on that same last SHOW cycle.
REQ-021 All outputs are registered; no combinational path from inputs to outputs.
REQ-022 i_enable low:
- On the next clock: state BLANK, cnt 0, idx 0, o_frame 0, all outputs off.
- Held there while i_enable stays low.
REQ-023 i_enable re-asserted: scanning restarts at digit 0 with a full p_blank dead time.
REQ-024 p_count = 1:
- idx is constant 0.
- o_frame pulses at the end of every slot.

Reset
REQ-025 i_rst low asynchronously forces:
- State BLANK, cnt 0, idx 0, holding register 0.
- o_sgmnt 0, o_dp 0, o_digit 0, o_frame 0.
REQ-026 Reset asserted mid-slot aborts the slot immediately; no partial digit remains lit.
REQ-027 After i_rst rises, the first clock is cnt 0 of a BLANK for digit 0.

Configuration
REQ-028 Macro SEG_LZ_BLANK_EN:
- Defined: leading-zero suppression is compiled in. A digit k > 0 shows o_sgmnt = 0 (dp still honoured) when i_value[k] and every higher-index digit equal 0; o_digit still strobes normally.
- Undefined: all digits decode per REQ-017/018 and the suppression logic is absent.

Verification
Bench parameters for all scenarios: p_count = 4, p_divider = 10, p_blank = 2; i_value = {4'd1, 4'd2, 4'd3, 4'd4} (digit 3..0); i_enable = 1.
REQ-029 Reset release, then run 40 clocks. Required:
- Cycles 0-1: o_digit 4'b0000.
- Cycles 2-9: o_digit 4'b0001 with o_sgmnt 7'h66.
- Cycles 12-19: 4'b0010 with 7'h4F.
- Digit 3 shows 7'h06.
- o_frame is high only at cycle 39.
REQ-030 i_value[0] changed from 4 to 9 at cycle 5 -> o_sgmnt stays 7'h66 until cycle 9; 7'h6F appears at cycle 42.
REQ-031 i_enable dropped at cycle 15 -> from cycle 16 o_digit 0 and o_sgmnt 0. Re-assert at cycle 20 -> 4'b0001 appears 3 cycles later, after the full BLANK.
REQ-032 i_rst pulsed low at cycle 25 (digit 2 lit) -> outputs 0 in the same cycle, without waiting for a clock edge. After release: BLANK, then digit 0.
REQ-033 i_value = {0, 0, 0, 7}, i_dp = 4'b0100:
- SEG_LZ_BLANK_EN defined: digits 3 and 2 give o_sgmnt 0; digit 2 gives o_dp 1; digit 1 gives 0; digit 0 gives 7'h07.
- Undefined: digits 3..1 give 7'h3F.
REQ-034 i_value[1] = 4'd12 -> digit 1 slot shows 7'h40.
